// File: rtl/mux_4x1_stream_if.sv
// Handshake bundle for mux_4x1_stream: four producer channels (data, valid,
// ready), the forced-select controls, and the single consumer channel.
//   slave  : the multiplexer side (takes producer data, drives y/y_valid).
//   master : the environment side (drives producer data, takes r* and y).
interface mux_4x1_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             v0, v1, v2, v3;
  logic             r0, r1, r2, r3;
  logic [1:0]       s;
  logic             sel_en;
  logic [WIDTH-1:0] y;
  logic [1:0]       y_sel;
  logic             y_valid;
  logic             y_ready;

  modport slave (
    input  in0, in1, in2, in3, v0, v1, v2, v3, s, sel_en, y_ready,
    output r0, r1, r2, r3, y, y_sel, y_valid
  );

  modport master (
    output in0, in1, in2, in3, v0, v1, v2, v3, s, sel_en, y_ready,
    input  r0, r1, r2, r3, y, y_sel, y_valid
  );
endinterface

// File: rtl/mux_4x1_stream.sv
// Registered 4-to-1 streaming multiplexer. Merges four valid/ready producer
// channels into one consumer channel, choosing by round-robin or by a forced
// 2-bit select, and tags each output beat with its source index.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mux_4x1_stream_if.slave (in0..3, v0..3, r0..3, s, sel_en,
//            y, y_sel, y_valid, y_ready)
module mux_4x1_stream #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  mux_4x1_stream_if.slave    bus
);

  logic [WIDTH-1:0] din [4];
  logic [3:0]       v_vec;
  logic [3:0]       elig;
  logic [3:0]       r_vec;
  logic [1:0]       rr_grant;
  logic [1:0]       grant;
  logic             any_elig;
  logic             load_en;
  logic             take;

  logic [WIDTH-1:0] y_q;
  logic [1:0]       y_sel_q;
  logic             y_valid_q;
  logic [1:0]       ptr;

  assign din[0] = bus.in0;
  assign din[1] = bus.in1;
  assign din[2] = bus.in2;
  assign din[3] = bus.in3;
  assign v_vec  = {bus.v3, bus.v2, bus.v1, bus.v0};

  // Output slot is free, or is being drained this very cycle. This makes
  // y_ready a combinational input to every r*.
  assign load_en = !y_valid_q || bus.y_ready;

  // In fixed mode only the selected channel can ever be eligible.
  assign elig     = bus.sel_en ? (v_vec & (4'b0001 << bus.s)) : v_vec;
  assign any_elig = |elig;

  // First eligible channel scanning ptr, ptr+1, ... (mod 4).
  always_comb begin
    // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
    rr_grant = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr + 2'(k)]) rr_grant = ptr + 2'(k);
    end
  end

  assign grant = bus.sel_en ? bus.s : rr_grant;

  // rst_n gating keeps every ready low during reset even though the empty
  // output slot would otherwise advertise space.
  assign take  = rst_n && load_en && any_elig;
  assign r_vec = take ? (4'b0001 << grant) : 4'b0000;

  assign bus.r0 = r_vec[0];
  assign bus.r1 = r_vec[1];
  assign bus.r2 = r_vec[2];
  assign bus.r3 = r_vec[3];

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // The data register is reset too: y must read 0 out of reset.
      y_q       <= '0;
      y_sel_q   <= '0;
      y_valid_q <= 1'b0;
      ptr       <= '0;
    end else if (take) begin
      y_q       <= din[grant];
      y_sel_q   <= grant;
      y_valid_q <= 1'b1;
      if (!bus.sel_en) ptr <= grant + 2'd1;
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_sel   = y_sel_q;
  assign bus.y_valid = y_valid_q;

endmodule
